// File: rtl/vga_mem_arbiter.sv
// Tile-based VGA raster that shares one synchronous tile-RAM port between display reads and a req/ack writer.
// Latency: memory port is registered 1 cycle after the raster position; pixel outputs are aligned 2 cycles after it.
// Backpressure: display reads always win; a writer request waits for a blanking position, then gets a one-cycle ack.
module vga_mem_arbiter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int TILE_SHIFT  = 3,
  parameter int ADDR_BITS   = 13,
  parameter int DATA_BITS   = 9
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Wr_Req,
  input  logic [ADDR_BITS-1:0] i_Wr_Addr,
  input  logic [DATA_BITS-1:0] i_Wr_Data,
  output logic                 o_Wr_Ack,
  output logic                 o_Wr_Err,
  output logic                 o_Mem_En,
  output logic                 o_Mem_We,
  output logic [ADDR_BITS-1:0] o_Mem_Addr,
  output logic [DATA_BITS-1:0] o_Mem_Wdata,
  input  logic [DATA_BITS-1:0] i_Mem_Rdata,
  output logic [9:0]           o_Col_Count,
  output logic [9:0]           o_Row_Count,
  output logic                 o_Pixel_Valid,
  output logic [DATA_BITS-1:0] o_Pixel_Data,
  output logic                 o_Frame_Start
);

  localparam int TILE_COLS = ACTIVE_COLS >> TILE_SHIFT;
  localparam int TILE_ROWS = ACTIVE_ROWS >> TILE_SHIFT;
  // One extra bit so the tile count itself is representable for the range check.
  localparam logic [ADDR_BITS:0] NUM_TILES = (ADDR_BITS+1)'(TILE_COLS * TILE_ROWS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} wr_state_t;

  wr_state_t r_State, w_Next_State;

  logic [9:0] r_Col, r_Row;
  logic [9:0] r_Col_D1, r_Row_D1, r_Col_D2, r_Row_D2;
  logic       r_Act_D1, r_Act_D2, r_Fs_D1, r_Fs_D2;

  logic                 r_Mem_En, r_Mem_We, r_Wr_Err;
  logic [ADDR_BITS-1:0] r_Mem_Addr;
  logic [DATA_BITS-1:0] r_Mem_Wdata;

  logic                 w_Mem_En, w_Mem_We, w_Wr_Err;
  logic [ADDR_BITS-1:0] w_Mem_Addr;
  logic [DATA_BITS-1:0] w_Mem_Wdata;

  logic                 w_Active, w_Col_Wrap, w_Row_Wrap, w_Origin, w_Addr_Bad;
  logic [ADDR_BITS-1:0] w_Tile_Addr;

  assign w_Active    = (r_Col < 10'(ACTIVE_COLS)) && (r_Row < 10'(ACTIVE_ROWS));
  assign w_Col_Wrap  = (r_Col == 10'(TOTAL_COLS - 1));
  assign w_Row_Wrap  = (r_Row == 10'(TOTAL_ROWS - 1));
  assign w_Origin    = (r_Col == 10'd0) && (r_Row == 10'd0);
  assign w_Tile_Addr = ADDR_BITS'(r_Row >> TILE_SHIFT) * ADDR_BITS'(TILE_COLS)
                     + ADDR_BITS'(r_Col >> TILE_SHIFT);
  assign w_Addr_Bad  = ({1'b0, i_Wr_Addr} >= NUM_TILES);

  // Raster counters: column wraps each line, row advances on column wrap.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Col <= '0;
      r_Row <= '0;
    end else if (w_Col_Wrap) begin
      r_Col <= '0;
      r_Row <= w_Row_Wrap ? 10'd0 : r_Row + 10'd1;
    end else begin
      r_Col <= r_Col + 10'd1;
    end
  end

  // Two-stage delay of position, active flag and frame-start so they line up with RAM read data.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Col_D1 <= '0;
      r_Row_D1 <= '0;
      r_Act_D1 <= 1'b0;
      r_Fs_D1  <= 1'b0;
      r_Col_D2 <= '0;
      r_Row_D2 <= '0;
      r_Act_D2 <= 1'b0;
      r_Fs_D2  <= 1'b0;
    end else begin
      r_Col_D1 <= r_Col;
      r_Row_D1 <= r_Row;
      r_Act_D1 <= w_Active;
      r_Fs_D1  <= w_Origin;
      r_Col_D2 <= r_Col_D1;
      r_Row_D2 <= r_Row_D1;
      r_Act_D2 <= r_Act_D1;
      r_Fs_D2  <= r_Fs_D1;
    end
  end

  // Writer state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next-state and memory-port selection: a display read owns the port; a waiting write takes blanking slots only.
  always_comb begin
    w_Next_State = r_State;
    w_Mem_En     = 1'b0;
    w_Mem_We     = 1'b0;
    w_Mem_Addr   = '0;
    w_Mem_Wdata  = '0;
    w_Wr_Err     = 1'b0;
    if (w_Active) begin
      w_Mem_En   = 1'b1;
      w_Mem_Addr = w_Tile_Addr;
    end
    case (r_State)
      S_IDLE: begin
        if (i_Wr_Req) w_Next_State = S_WAIT;
      end
      S_WAIT: begin
        if (!w_Active) begin
          w_Next_State = S_ACK;
          w_Wr_Err     = w_Addr_Bad;
          // Out-of-range writes are acknowledged with an error but never reach the RAM.
          if (!w_Addr_Bad) begin
            w_Mem_En    = 1'b1;
            w_Mem_We    = 1'b1;
            w_Mem_Addr  = i_Wr_Addr;
            w_Mem_Wdata = i_Wr_Data;
          end
        end
      end
      S_ACK:   w_Next_State = S_IDLE;
      default: w_Next_State = S_IDLE;
    endcase
  end

  // Registered memory port and error flag; the ACK state coincides with the write on the port.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Mem_En    <= 1'b0;
      r_Mem_We    <= 1'b0;
      r_Mem_Addr  <= '0;
      r_Mem_Wdata <= '0;
      r_Wr_Err    <= 1'b0;
    end else begin
      r_Mem_En    <= w_Mem_En;
      r_Mem_We    <= w_Mem_We;
      r_Mem_Addr  <= w_Mem_Addr;
      r_Mem_Wdata <= w_Mem_Wdata;
      r_Wr_Err    <= w_Wr_Err;
    end
  end

  assign o_Mem_En      = r_Mem_En;
  assign o_Mem_We      = r_Mem_We;
  assign o_Mem_Addr    = r_Mem_Addr;
  assign o_Mem_Wdata   = r_Mem_Wdata;
  assign o_Wr_Ack      = (r_State == S_ACK);
  assign o_Wr_Err      = r_Wr_Err;
  assign o_Col_Count   = r_Col_D2;
  assign o_Row_Count   = r_Row_D2;
  assign o_Pixel_Valid = r_Act_D2;
  assign o_Frame_Start = r_Fs_D2;
  assign o_Pixel_Data  = r_Act_D2 ? i_Mem_Rdata : '0;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural 1-cycle synchronous RAM.
// Raster is shrunk (100x70 total, 80x48 active, 10x6 tiles) so several frames fit in a short run.
// Positions (c,r) in frame f map to cycle f*7000 + r*100 + c counted from reset release.
module tb_vga_mem_arbiter;
  localparam int TC = 100, TR = 70, AC = 80, AR = 48, TS = 3, AB = 13, DB = 9;
  localparam int TCOLS = AC >> TS;
  localparam int FRAME = TC * TR;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          wr_ack, wr_err, mem_en, mem_we;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata, mem_rdata, pix_dat;
  logic [9:0]    col, row;
  logic          pix_vld, frame_start;

  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .TILE_SHIFT(TS), .ADDR_BITS(AB), .DATA_BITS(DB)
  ) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Wr_Req(wr_req), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
    .o_Wr_Ack(wr_ack), .o_Wr_Err(wr_err),
    .o_Mem_En(mem_en), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr), .o_Mem_Wdata(mem_wdata),
    .i_Mem_Rdata(mem_rdata),
    .o_Col_Count(col), .o_Row_Count(row), .o_Pixel_Valid(pix_vld),
    .o_Pixel_Data(pix_dat), .o_Frame_Start(frame_start)
  );

  // Unwritten RAM words hold a fixed address-derived pattern.
  function automatic logic [DB-1:0] pattern(input logic [AB-1:0] a);
    return DB'(32'(a) * 37 + 5);
  endfunction

  logic [DB-1:0] ram    [0:(1<<AB)-1];
  logic          ram_wr [0:(1<<AB)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= (ram_wr[mem_addr] === 1'b1) ? ram[mem_addr] : pattern(mem_addr);
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end
    end
  end

  function automatic int mc(int k);   return k % TC; endfunction
  function automatic int mr(int k);   return (k / TC) % TR; endfunction
  function automatic bit mact(int k); return (mc(k) < AC) && (mr(k) < AR); endfunction
  function automatic int mtile(int k); return (mr(k) >> TS) * TCOLS + (mc(k) >> TS); endfunction
  function automatic int pos(int f, int c, int r); return f * FRAME + r * TC + c; endfunction

  function automatic logic [56:0] all_outs();
    return {mem_en, mem_we, mem_addr, mem_wdata, wr_ack, wr_err, col, row, pix_vld, pix_dat, frame_start};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) step();
  endtask

  // Raise a request during cycle k0 and run until ack (bounded); captures the port on the ack cycle.
  task automatic issue_req(input int k0, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           output int ack_cyc, output bit we_early,
                           output logic [AB+DB+2:0] cap, output logic ack_after);
    wait_to(k0);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    ack_cyc = -1; we_early = 1'b0; cap = '0; ack_after = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (wr_ack === 1'b1) begin
        ack_cyc = cyc;
        cap = {mem_en, mem_we, wr_err, mem_addr, mem_wdata};
        wr_req = 1'b0;
        step();
        ack_after = wr_ack | wr_err;
        break;
      end
      if (mem_we === 1'b1 || wr_err === 1'b1) we_early = 1'b1;
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs() !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    rst = 1'b0;
    cyc = 0;
    n_cmp++;
    if ({mem_en, col, row, pix_vld, frame_start} !== '0)
      begin n_err++; $display("FAIL release_cycle0: got %h expected 0", {mem_en, col, row, pix_vld, frame_start}); end
  endtask

  task automatic test_frame();
    int rd_cnt = 0, fs_first = -1, fs_second = -1, fs_other = 0, port_bad = 0, align_bad = 0, k;
    logic [DB-1:0] exp_dat;
    for (int i = 0; i <= FRAME + 2; i++) begin
      if (i > 0) step();
      if (cyc >= 1 && cyc <= FRAME && mem_en === 1'b1 && mem_we === 1'b0) rd_cnt++;
      if (cyc == 0) begin
        if (mem_en !== 1'b0) port_bad++;
      end else if (mem_en !== mact(cyc-1) || mem_we !== 1'b0 ||
                   (mact(cyc-1) && mem_addr !== AB'(mtile(cyc-1)))) port_bad++;
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
        else fs_other++;
      end
      if (cyc >= 2) begin
        k = cyc - 2;
        exp_dat = mact(k) ? pattern(AB'(mtile(k))) : '0;
        if (col !== 10'(mc(k)) || row !== 10'(mr(k)) || pix_vld !== mact(k) ||
            frame_start !== (k % FRAME == 0) || pix_dat !== exp_dat) align_bad++;
      end else if ({col, row, pix_vld, frame_start} !== '0) align_bad++;
    end
    n_cmp++; if (fs_first != 2) begin n_err++; $display("FAIL frame_start_first: got %0d expected 2", fs_first); end
    n_cmp++; if (fs_second != FRAME + 2) begin n_err++; $display("FAIL frame_start_second: got %0d expected %0d", fs_second, FRAME + 2); end
    n_cmp++; if (fs_other != 0) begin n_err++; $display("FAIL frame_start_extra: got %0d expected 0", fs_other); end
    n_cmp++; if (rd_cnt != AC * AR) begin n_err++; $display("FAIL read_count: got %0d expected %0d", rd_cnt, AC * AR); end
    n_cmp++; if (port_bad != 0) begin n_err++; $display("FAIL read_port_cycles: got %0d bad cycles expected 0", port_bad); end
    n_cmp++; if (align_bad != 0) begin n_err++; $display("FAIL pixel_alignment: got %0d bad cycles expected 0", align_bad); end
  endtask

  task automatic test_tile_read();
    wait_to(pos(1, 8, 8));
    step();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 13'd11})
      begin n_err++; $display("FAIL tile_addr_8_8: got en=%b we=%b addr=%0d expected en=1 we=0 addr=11", mem_en, mem_we, mem_addr); end
    step();
    n_cmp++;
    if ({col, row, pix_vld} !== {10'd8, 10'd8, 1'b1})
      begin n_err++; $display("FAIL align_8_8: got col=%0d row=%0d vld=%b expected 8 8 1", col, row, pix_vld); end
    n_cmp++;
    if (pix_dat !== 9'h19C) begin n_err++; $display("FAIL pixel_8_8: got %h expected 19c", pix_dat); end
    wait_to(pos(1, 79, 47));
    step();
    n_cmp++;
    if (mem_addr !== 13'd59) begin n_err++; $display("FAIL tile_addr_last: got %0d expected 59", mem_addr); end
  endtask

  task automatic test_write_wait();
    int ack_cyc; bit early; logic [AB+DB+2:0] cap; logic after;
    issue_req(pos(2, 50, 2), 13'd33, 9'h1FF, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(2, 81, 2)) begin n_err++; $display("FAIL wait_ack_cycle: got %0d expected %0d", ack_cyc, pos(2, 81, 2)); end
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL wait_early_write: got %b expected 0", early); end
    n_cmp++; if (cap !== {3'b110, 13'd33, 9'h1FF}) begin n_err++; $display("FAIL wait_write_port: got %h expected %h", cap, {3'b110, 13'd33, 9'h1FF}); end
    n_cmp++; if (after !== 1'b0) begin n_err++; $display("FAIL wait_ack_width: got %b expected 0", after); end
    wait_to(pos(3, 24, 24) + 2);
    n_cmp++;
    if ({col, row, pix_dat} !== {10'd24, 10'd24, 9'h1FF})
      begin n_err++; $display("FAIL readback_tile33: got col=%0d row=%0d dat=%h expected 24 24 1ff", col, row, pix_dat); end
  endtask

  task automatic test_addr_err();
    int ack_cyc; bit early; logic [AB+DB+2:0] cap; logic after;
    int we_seen = 0;
    issue_req(pos(4, 85, 5), 13'd60, 9'h0F0, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(4, 87, 5)) begin n_err++; $display("FAIL err_ack_cycle: got %0d expected %0d", ack_cyc, pos(4, 87, 5)); end
    n_cmp++; if (cap[AB+DB+2 -: 3] !== 3'b001) begin n_err++; $display("FAIL err_flags: got en,we,err=%b expected 001", cap[AB+DB+2 -: 3]); end
    n_cmp++; if (after !== 1'b0) begin n_err++; $display("FAIL err_pulse_width: got %b expected 0", after); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_we === 1'b1) we_seen++;
    end
    n_cmp++; if (early !== 1'b0 || we_seen != 0) begin n_err++; $display("FAIL err_no_write: got early=%b later=%0d expected 0 0", early, we_seen); end
    issue_req(pos(4, 85, 6), 13'd59, 9'h0A5, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(4, 87, 6)) begin n_err++; $display("FAIL last_tile_ack: got %0d expected %0d", ack_cyc, pos(4, 87, 6)); end
    n_cmp++; if (cap !== {3'b110, 13'd59, 9'h0A5}) begin n_err++; $display("FAIL last_tile_port: got %h expected %h", cap, {3'b110, 13'd59, 9'h0A5}); end
  endtask

  task automatic test_edges();
    int ack_cyc; bit early; logic [AB+DB+2:0] cap; logic after;
    issue_req(pos(5, 79, 47), 13'd5, 9'h0AA, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(5, 81, 47)) begin n_err++; $display("FAIL edge_last_active_ack: got %0d expected %0d", ack_cyc, pos(5, 81, 47)); end
    n_cmp++; if (cap !== {3'b110, 13'd5, 9'h0AA}) begin n_err++; $display("FAIL edge_last_active_port: got %h expected %h", cap, {3'b110, 13'd5, 9'h0AA}); end
    issue_req(pos(5, 99, 69), 13'd6, 9'h055, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(6, 81, 0)) begin n_err++; $display("FAIL edge_frame_end_ack: got %0d expected %0d", ack_cyc, pos(6, 81, 0)); end
    n_cmp++; if (early !== 1'b0 || cap !== {3'b110, 13'd6, 9'h055}) begin n_err++; $display("FAIL edge_frame_end_port: got early=%b port=%h expected 0 %h", early, cap, {3'b110, 13'd6, 9'h055}); end
    issue_req(pos(6, 98, 69), 13'd7, 9'h123, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != pos(7, 0, 0)) begin n_err++; $display("FAIL edge_wait_at_last_blank: got %0d expected %0d", ack_cyc, pos(7, 0, 0)); end
    n_cmp++; if (cap !== {3'b110, 13'd7, 9'h123}) begin n_err++; $display("FAIL edge_wait_port: got %h expected %h", cap, {3'b110, 13'd7, 9'h123}); end
  endtask

  task automatic test_reset_mid();
    int ack_cyc; bit early; logic [AB+DB+2:0] cap; logic after;
    int pre_bad = 0, rst_bad = 0;
    wait_to(pos(7, 10, 1));
    wr_req = 1'b1; wr_addr = 13'd8; wr_data = 9'h0CC;
    while (cyc < pos(7, 20, 1)) begin
      step();
      if (wr_ack !== 1'b0 || mem_we !== 1'b0) pre_bad++;
    end
    n_cmp++; if (pre_bad != 0) begin n_err++; $display("FAIL mid_wait_no_ack: got %0d bad cycles expected 0", pre_bad); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (all_outs() !== '0) begin n_err++; $display("FAIL async_reset_outputs: got %h expected 0", all_outs()); end
    repeat (3) begin
      @(negedge clk);
      if (all_outs() !== '0) rst_bad++;
    end
    n_cmp++; if (rst_bad != 0) begin n_err++; $display("FAIL held_reset_outputs: got %0d bad cycles expected 0", rst_bad); end
    rst = 1'b0;
    cyc = 0;
    issue_req(0, 13'd8, 9'h0CC, ack_cyc, early, cap, after);
    n_cmp++; if (ack_cyc != 81) begin n_err++; $display("FAIL restart_ack_cycle: got %0d expected 81", ack_cyc); end
    n_cmp++; if (early !== 1'b0 || cap !== {3'b110, 13'd8, 9'h0CC}) begin n_err++; $display("FAIL restart_port: got early=%b port=%h expected 0 %h", early, cap, {3'b110, 13'd8, 9'h0CC}); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_tile_read();
    test_write_wait();
    test_addr_err();
    test_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
